// File: rtl/flex_aggregator.sv
`default_nettype none
// ============================================================================
//  Module   : flex_aggregator
//  Purpose  : Dequeues DATA_WIDTH words from a FIFO-style sender and packs
//             them into a wide group of up to MAX_FETCH lanes. The group size
//             is selected at run time for each group, and a flush closes a
//             partial group. The collect stage and the output register form a
//             two-deep buffer, so words keep flowing while the receiver stalls.
//  Ports    :
//    clk             - clock, all logic on the rising edge
//    rst             - synchronous active-high reset
//    cfg_fetch       - requested group size, latched at the first word of a group
//    flush           - single-cycle request to close the current partial group
//    sender_data     - sender head word
//    sender_empty_n  - sender has data
//    sender_deq      - pop the sender this cycle
//    receiver_data   - packed group, lane 0 in the lowest bits
//    receiver_mask   - one bit per valid lane
//    receiver_count  - number of valid lanes
//    receiver_full_n - receiver can accept
//    receiver_enq    - push to the receiver this cycle
//    busy            - collect stage holds words or the output register is valid
//  Revision : 1.0 - initial release
// ============================================================================
module flex_aggregator #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_FETCH  = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CNT_WIDTH-1:0]            cfg_fetch,
    input  logic                            flush,
    input  logic [DATA_WIDTH-1:0]           sender_data,
    input  logic                            sender_empty_n,
    output logic                            sender_deq,
    output logic [MAX_FETCH*DATA_WIDTH-1:0] receiver_data,
    output logic [MAX_FETCH-1:0]            receiver_mask,
    output logic [CNT_WIDTH-1:0]            receiver_count,
    input  logic                            receiver_full_n,
    output logic                            receiver_enq,
    output logic                            busy
);

    localparam int                   c_BUS_W = MAX_FETCH * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] c_MAX   = CNT_WIDTH'(MAX_FETCH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_idx;
    logic [CNT_WIDTH-1:0]   r_fetch;
    logic [c_BUS_W-1:0]     r_coll;
    logic                   r_flush_pend;
    logic                   r_rst_d;
    logic                   r_out_valid;
    logic [c_BUS_W-1:0]     r_out_data;
    logic [MAX_FETCH-1:0]   r_out_mask;
    logic [CNT_WIDTH-1:0]   r_out_count;

    logic [CNT_WIDTH-1:0]   w_fetch_eff;
    logic [CNT_WIDTH-1:0]   w_limit;
    logic [CNT_WIDTH-1:0]   w_idx_inc;
    logic [CNT_WIDTH-1:0]   w_close_count;
    logic [c_BUS_W-1:0]     w_coll_next;
    logic                   w_flush_any;
    logic                   w_deq;
    logic                   w_enq;
    logic                   w_slot_free;
    logic                   w_close;
    logic                   w_hold_xfer;

    // Thermometer mask: lanes below cnt are valid.
    function automatic logic [MAX_FETCH-1:0] mask_of(input logic [CNT_WIDTH-1:0] cnt);
        logic [MAX_FETCH-1:0] m;
        m = '0;
        for (int k = 0; k < MAX_FETCH; k++) begin
            m[k] = (CNT_WIDTH'(k) < cnt);
        end
        return m;
    endfunction

    // Out-of-range or zero requests fall back to the widest group.
    assign w_fetch_eff = ((cfg_fetch == '0) || (cfg_fetch > c_MAX)) ? c_MAX : cfg_fetch;
    // In IDLE the live request governs the first word; afterwards the latched one.
    assign w_limit     = (r_state == S_IDLE) ? w_fetch_eff : r_fetch;
    assign w_flush_any = flush | r_flush_pend;
    assign w_idx_inc   = r_idx + 1'b1;

    // The cycle following reset is kept quiet on both handshakes.
    assign w_deq       = !rst && !r_rst_d && (r_state != S_HOLD) && sender_empty_n;
    assign w_enq       = !rst && r_out_valid && receiver_full_n;
    assign w_slot_free = !r_out_valid || w_enq;

    // Collect image including the word popped this cycle, so a closing group
    // can move straight into the output register without an extra cycle.
    always_comb begin
        w_coll_next = r_coll;
        if (w_deq) begin
            for (int k = 0; k < MAX_FETCH; k++) begin
                if (r_idx == CNT_WIDTH'(k)) begin
                    w_coll_next[k*DATA_WIDTH +: DATA_WIDTH] = sender_data;
                end
            end
        end
    end

    // A group closes on reaching its size, or on a flush (with or without a
    // word arriving); a flush with an empty IDLE stage has nothing to close.
    assign w_close = (r_state != S_HOLD) &&
                     ((w_deq && ((w_idx_inc == w_limit) || w_flush_any)) ||
                      ((r_state == S_FILL) && w_flush_any));
    assign w_close_count = w_deq ? w_idx_inc : r_idx;
    assign w_hold_xfer   = (r_state == S_HOLD) && w_slot_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_fetch      <= '0;
            r_coll       <= '0;
            r_flush_pend <= 1'b0;
            r_rst_d      <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_mask   <= '0;
            r_out_count  <= '0;
        end else begin
            r_rst_d <= 1'b0;

            // Output register: load a freshly closed or held group, otherwise
            // retire the current one once the receiver takes it.
            if (w_close && w_slot_free) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_coll_next;
                r_out_count <= w_close_count;
                r_out_mask  <= mask_of(w_close_count);
            end else if (w_hold_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_coll;
                r_out_count <= r_idx;
                r_out_mask  <= mask_of(r_idx);
            end else if (w_enq) begin
                r_out_valid <= 1'b0;
            end

            // Collect stage. Clearing r_coll on transfer keeps unused lanes zero.
            if (w_close) begin
                if (w_slot_free) begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                    r_coll  <= '0;
                end else begin
                    r_state <= S_HOLD;
                    r_idx   <= w_close_count;
                    r_coll  <= w_coll_next;
                end
            end else if (w_hold_xfer) begin
                r_state <= S_IDLE;
                r_idx   <= '0;
                r_coll  <= '0;
            end else if (w_deq) begin
                r_state <= S_FILL;
                r_idx   <= w_idx_inc;
                r_coll  <= w_coll_next;
            end

            if ((r_state == S_IDLE) && w_deq) begin
                r_fetch <= w_fetch_eff;
            end

            // A pending flush is dropped once a group closes, when it has
            // nothing to act on in IDLE, or when the group is already held.
            if (w_close || (r_state == S_HOLD) || ((r_state == S_IDLE) && !w_deq)) begin
                r_flush_pend <= 1'b0;
            end else if (flush) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    assign sender_deq     = w_deq;
    assign receiver_enq   = w_enq;
    assign receiver_data  = r_out_data;
    assign receiver_mask  = r_out_mask;
    assign receiver_count = r_out_count;
    assign busy           = (r_state != S_IDLE) || r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_flex_aggregator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flex_aggregator
//  Purpose  : Randomised self-checking bench for flex_aggregator. A
//             transaction-level model partitions the dequeued word stream
//             into groups and tracks how many closed groups await delivery.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flex_aggregator;

    localparam int DW = 16;
    localparam int MF = 8;
    localparam int CW = 4;
    localparam int BW = MF * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] cfg_fetch;
    logic          flush;
    logic [DW-1:0] sender_data;
    logic          sender_empty_n;
    logic          sender_deq;
    logic [BW-1:0] receiver_data;
    logic [MF-1:0] receiver_mask;
    logic [CW-1:0] receiver_count;
    logic          receiver_full_n;
    logic          receiver_enq;
    logic          busy;

    flex_aggregator #(
        .DATA_WIDTH (DW),
        .MAX_FETCH  (MF),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_fetch       (cfg_fetch),
        .flush           (flush),
        .sender_data     (sender_data),
        .sender_empty_n  (sender_empty_n),
        .sender_deq      (sender_deq),
        .receiver_data   (receiver_data),
        .receiver_mask   (receiver_mask),
        .receiver_count  (receiver_count),
        .receiver_full_n (receiver_full_n),
        .receiver_enq    (receiver_enq),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: closed groups awaiting delivery, plus the open group.
    typedef struct {
        logic [BW-1:0] data;
        int            count;
    } grp_t;

    grp_t          closed_q[$];
    logic [BW-1:0] open_data  = '0;
    int            open_n     = 0;
    int            open_fetch = MF;
    bit            rst_recent = 1'b0;
    logic [DW-1:0] head;
    int            deq_seen   = 0;

    // Stimulus knobs (percentages; reset in per-mille)
    int k_src     = 100;
    int k_dst     = 100;
    int k_flush   = 0;
    int k_cfg     = 4;
    int k_cfg_chg = 0;
    int k_rst_pm  = 0;
    bit force_rst = 1'b1;

    function automatic int eff(input int c);
        return ((c == 0) || (c > MF)) ? MF : c;
    endfunction

    task automatic close_group();
        grp_t g;
        g.data  = open_data;
        g.count = open_n;
        closed_q.push_back(g);
        open_n    = 0;
        open_data = '0;
    endtask

    task automatic step();
        bit            exp_deq;
        bit            exp_enq;
        logic [BW-1:0] exp_mask;
        @(negedge clk);
        sender_empty_n  = ($urandom_range(99) < k_src);
        receiver_full_n = ($urandom_range(99) < k_dst);
        flush           = ($urandom_range(99) < k_flush);
        if (k_cfg >= 0)
            cfg_fetch = CW'(k_cfg);
        else if ($urandom_range(99) < k_cfg_chg)
            cfg_fetch = CW'($urandom_range(12));
        rst         = force_rst || ($urandom_range(999) < k_rst_pm);
        sender_data = head;
        #1;
        // Two closed groups outstanding means the collect stage is holding.
        exp_deq = !rst && !rst_recent && sender_empty_n && (closed_q.size() < 2);
        exp_enq = !rst && (closed_q.size() > 0) && receiver_full_n;
        check("sender_deq", 128'(sender_deq), 128'(exp_deq));
        check("receiver_enq", 128'(receiver_enq), 128'(exp_enq));
        if (!rst)
            check("busy", 128'(busy), 128'((closed_q.size() > 0) || (open_n > 0)));
        if (exp_enq) begin
            exp_mask = (BW'(1) << closed_q[0].count) - BW'(1);
            check("receiver_data", 128'(receiver_data), 128'(closed_q[0].data));
            check("receiver_count", 128'(receiver_count), 128'(closed_q[0].count));
            check("receiver_mask", 128'(receiver_mask), 128'(exp_mask));
        end
        if (rst_recent && !rst) begin
            check("reset_data", 128'(receiver_data), 128'(0));
            check("reset_mask", 128'(receiver_mask), 128'(0));
            check("reset_count", 128'(receiver_count), 128'(0));
        end
        if (sender_deq) deq_seen++;

        if (exp_enq) void'(closed_q.pop_front());
        if (rst) begin
            closed_q.delete();
            open_n     = 0;
            open_data  = '0;
            rst_recent = 1'b1;
        end else begin
            rst_recent = 1'b0;
            if (exp_deq) begin
                if (open_n == 0) open_fetch = eff(int'(cfg_fetch));
                open_data[open_n*DW +: DW] = head;
                open_n++;
                head = DW'($urandom);
                if ((open_n == open_fetch) || flush) close_group();
            end else if (flush && (open_n > 0)) begin
                close_group();
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst             = 1'b1;
        cfg_fetch       = CW'(4);
        flush           = 1'b0;
        sender_empty_n  = 1'b0;
        receiver_full_n = 1'b1;
        head            = DW'($urandom);
        sender_data     = head;

        // Reset, then the quiet cycle after it
        force_rst = 1'b1;
        run(2);
        force_rst = 1'b0;

        // Groups of 4 at full rate
        k_cfg = 4; k_src = 100; k_dst = 100; k_flush = 0;
        run(20);

        // Groups of 1 back to back
        k_cfg = 1;
        run(15);

        // Drain, then stall the receiver: exactly two groups of 4 absorbed
        k_src = 0; k_dst = 100;
        run(3);
        k_cfg = 4; k_src = 100; k_dst = 0;
        deq_seen = 0;
        run(20);
        check("stall_deq_count", 128'(deq_seen), 128'(8));
        k_dst = 100;
        run(15);

        // Groups of 8 with flushes closing partial groups
        k_cfg = 8; k_src = 70; k_flush = 15;
        run(60);

        // Reset with a group in the output register and two words collected
        k_flush = 0; k_src = 0;
        run(3);
        k_cfg = 4; k_src = 100; k_dst = 0;
        run(6);
        force_rst = 1'b1;
        run(1);
        force_rst = 1'b0;
        k_dst = 100;
        run(20);

        // Random sizes (including 0 and > MAX_FETCH) changing mid-group
        k_cfg = -1; k_cfg_chg = 30; k_src = 70; k_dst = 70; k_flush = 5;
        run(400);

        // Long random run with occasional resets and heavy backpressure
        k_src = 85; k_dst = 40; k_flush = 8; k_rst_pm = 5;
        run(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
